// File: rtl/spi_frame_pkg.sv
// Shared types and constants for the SPI frame handler.
// The optional frame CRC is enabled by defining FRAME_CRC_EN.
package spi_frame_pkg;

  localparam logic [7:0] CRC8_POLY = 8'h07;
  localparam int ID_W  = 32;
  localparam int SEQ_W = 8;
  localparam int CRC_W = 8;

  typedef enum logic [2:0] {
    IDLE,
    CHECK,
    VERIFY,
    COMMIT,
    ERROR
  } state_t;

  function automatic int payload_w(input int bs);
    return bs - ID_W - SEQ_W - CRC_W;
  endfunction

endpackage

// File: rtl/spi_frame_handler_crc8.sv
// One byte step of CRC-8 (poly 0x07, MSB first, no reflection).
// Combinational; chained one byte per clock by the frame handler.
module crc8_byte
  import spi_frame_pkg::*;
(
  input  logic [7:0] crc_in,
  input  logic [7:0] data,
  output logic [7:0] crc_out
);

  logic [7:0] c;

  always_comb begin
    c = crc_in ^ data;
    for (int i = 0; i < 8; i++) begin
      if (c[7]) c = {c[6:0], 1'b0} ^ CRC8_POLY;
      else      c = {c[6:0], 1'b0};
    end
    crc_out = c;
  end

endmodule

// File: rtl/spi_frame_handler.sv
// Unpacks, checks and commits SPI frames; builds the tx response frame.
// Define FRAME_CRC_EN to check rx CRC and generate tx CRC.
module spi_frame_handler
  import spi_frame_pkg::*;
#(
  parameter int              BUFFER_SIZE = 128,
  parameter logic [ID_W-1:0] TX_ID       = 32'h64617461,
  parameter int              MAX_ERR     = 4,
  localparam int             PW = payload_w(BUFFER_SIZE)
)(
  input  logic                   clk,
  input  logic                   rst,
  input  logic [BUFFER_SIZE-1:0] rx_data,
  input  logic                   rx_sync,
  input  logic                   pkg_timeout,
  input  logic [PW-1:0]          in_payload,
  output logic [PW-1:0]          out_payload,
  output logic                   out_valid,
  output logic                   out_enable,
  output logic [BUFFER_SIZE-1:0] tx_data,
  output logic                   seq_gap,
  output logic [15:0]            frame_count,
  output logic [7:0]             err_count
);

  localparam int BS = BUFFER_SIZE;
  localparam int NB = BS / 8;
  localparam int CW = $clog2(MAX_ERR + 1);

  state_t state, state_nx;

  logic [BS-1:0]    rbuf;
  logic [BS-9:0]    tbuf;
  logic [SEQ_W-1:0] rx_seq, last_seq;
  logic             seq_known;
  logic             en_q;
  logic [CW-1:0]    consec_err, consec_nx;
  logic [8:0]       err_sum;
  logic             snap, commit, fail, overrun;
  logic             crc_ok, last_byte;
  logic [7:0]       tx_crc_fin;

  assign snap    = (state == IDLE) && rx_sync;
  assign overrun = (state != IDLE) && rx_sync;
  assign rx_seq  = rbuf[CRC_W+PW +: SEQ_W];

`ifdef FRAME_CRC_EN
  localparam bit CRC_ON = 1'b1;
  localparam int IW = $clog2(NB);

  logic [IW-1:0] byte_idx;
  logic [7:0]    rx_crc, tx_crc;
  logic [7:0]    rx_crc_nx, tx_crc_nx;
  logic [7:0]    rx_byte, tx_byte;

  // byte 0 is the most significant byte of each buffer
  assign rx_byte = rbuf[8*(NB-1-int'(byte_idx)) +: 8];
  assign tx_byte = tbuf[8*(NB-2-int'(byte_idx)) +: 8];

  crc8_byte u_rx_crc (
    .crc_in  (rx_crc),
    .data    (rx_byte),
    .crc_out (rx_crc_nx)
  );

  crc8_byte u_tx_crc (
    .crc_in  (tx_crc),
    .data    (tx_byte),
    .crc_out (tx_crc_nx)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      rx_crc   <= '0;
      tx_crc   <= '0;
      byte_idx <= '0;
    end else if (snap) begin
      rx_crc   <= '0;
      tx_crc   <= '0;
      byte_idx <= '0;
    end else if (state == CHECK) begin
      rx_crc   <= rx_crc_nx;
      tx_crc   <= tx_crc_nx;
      byte_idx <= byte_idx + IW'(1);
    end
  end

  assign crc_ok     = (rx_crc == rbuf[CRC_W-1:0]);
  assign last_byte  = (byte_idx == IW'(NB-2));
  assign tx_crc_fin = tx_crc;
`else
  localparam bit CRC_ON = 1'b0;

  logic unused_rx;

  assign unused_rx  = ^{rbuf[BS-1 -: ID_W], rbuf[CRC_W-1:0]};
  assign crc_ok     = 1'b1;
  assign last_byte  = 1'b1;
  assign tx_crc_fin = 8'h00;
`endif

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    commit   = 1'b0;
    fail     = 1'b0;
    unique case (state)
      IDLE: begin
        if (rx_sync) state_nx = CRC_ON ? CHECK : COMMIT;
      end
      CHECK: begin
        if (last_byte) state_nx = VERIFY;
      end
      VERIFY: begin
        state_nx = crc_ok ? COMMIT : ERROR;
      end
      COMMIT: begin
        commit   = 1'b1;
        state_nx = IDLE;
      end
      ERROR: begin
        fail     = 1'b1;
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  assign consec_nx = (consec_err == CW'(MAX_ERR))
                   ? consec_err : consec_err + CW'(1);

  // a bad frame and an overrun can land on the same edge
  assign err_sum = {1'b0, err_count}
                 + {8'd0, overrun}
                 + {8'd0, fail};

  always_ff @(posedge clk) begin
    if (rst) begin
      rbuf        <= '0;
      tbuf        <= '0;
      out_payload <= '0;
      out_valid   <= 1'b0;
      seq_gap     <= 1'b0;
      frame_count <= '0;
      err_count   <= '0;
      tx_data     <= {TX_ID, {(BS-ID_W){1'b0}}};
      en_q        <= 1'b0;
      consec_err  <= '0;
      seq_known   <= 1'b0;
      last_seq    <= '0;
    end else begin
      out_valid <= 1'b0;
      seq_gap   <= 1'b0;
      err_count <= err_sum[8] ? 8'hFF : err_sum[7:0];
      if (snap) begin
        rbuf <= rx_data;
        tbuf <= {TX_ID,
                 rx_data[CRC_W+PW +: SEQ_W],
                 in_payload};
      end
      if (commit) begin
        out_payload <= rbuf[CRC_W +: PW];
        out_valid   <= 1'b1;
        frame_count <= frame_count + 16'd1;
        tx_data     <= {tbuf, tx_crc_fin};
        consec_err  <= '0;
        en_q        <= 1'b1;
        if (seq_known && rx_seq != last_seq + 8'd1)
          seq_gap <= 1'b1;
        last_seq  <= rx_seq;
        seq_known <= 1'b1;
      end
      if (fail) begin
        consec_err <= consec_nx;
        if (consec_nx == CW'(MAX_ERR)) en_q <= 1'b0;
      end
      // link timeout overrides a same-cycle commit
      if (pkg_timeout) begin
        en_q      <= 1'b0;
        seq_known <= 1'b0;
      end
    end
  end

  assign out_enable = en_q && !pkg_timeout;

endmodule

// File: tb/tb_spi_frame_handler.sv
// Directed bench for spi_frame_handler with a frame-level reference model.
// Build with or without FRAME_CRC_EN to match the RTL.
module tb_spi_frame_handler;
  import spi_frame_pkg::*;

  localparam int BS = 96;
  localparam int PW = 48;
  localparam int NB = 12;
  localparam int MAXE = 4;
  localparam logic [31:0] TXID = 32'h64617461;
  localparam logic [31:0] RXID = 32'h12345678;
`ifdef FRAME_CRC_EN
  localparam bit CRC_ON = 1'b1;
  localparam int LAT = 14;
`else
  localparam bit CRC_ON = 1'b0;
  localparam int LAT = 2;
`endif

  logic          clk, rst, rx_sync, pkg_timeout;
  logic [BS-1:0] rx_data, tx_data;
  logic [PW-1:0] in_payload, out_payload;
  logic          out_valid, out_enable, seq_gap;
  logic [15:0]   frame_count;
  logic [7:0]    err_count;
  logic [7:0]    c_in, c_byte, c_out;

  spi_frame_handler #(
    .BUFFER_SIZE (BS),
    .TX_ID       (TXID),
    .MAX_ERR     (MAXE)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .rx_data     (rx_data),
    .rx_sync     (rx_sync),
    .pkg_timeout (pkg_timeout),
    .in_payload  (in_payload),
    .out_payload (out_payload),
    .out_valid   (out_valid),
    .out_enable  (out_enable),
    .tx_data     (tx_data),
    .seq_gap     (seq_gap),
    .frame_count (frame_count),
    .err_count   (err_count)
  );

  crc8_byte u_crc (
    .crc_in  (c_in),
    .data    (c_byte),
    .crc_out (c_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int valid_cnt = 0;
  int gap_cnt = 0;

  task automatic chk(input string name,
                     input logic [BS-1:0] act,
                     input logic [BS-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual %h required %h", name, act, exp);
    end
  endtask

  // bit-serial CRC-8 over the top n bytes of v
  function automatic logic [7:0] crc_bytes(input logic [BS-1:0] v,
                                           input int n);
    logic [7:0] c;
    logic fb;
    c = 8'h00;
    for (int i = BS - 1; i >= BS - 8 * n; i--) begin
      fb = c[7] ^ v[i];
      c = {c[6:0], 1'b0};
      if (fb) c = c ^ 8'h07;
    end
    return c;
  endfunction

  // reference model: frame-level events scheduled at their commit cycle
  int            cyc = 0;
  int            due = 0;
  bit            pend = 0, busy = 0, p_good = 0;
  logic [7:0]    p_seq, m_last;
  logic [PW-1:0] p_payload, m_payload;
  logic [BS-1:0] p_tx, m_tx;
  logic          m_valid, m_gap, m_en, m_known;
  logic [15:0]   m_fc;
  int            m_ec = 0, m_consec = 0;

  always @(posedge clk) begin
    m_valid = 1'b0;
    m_gap = 1'b0;
    if (rst) begin
      m_payload = '0;
      m_fc = '0;
      m_ec = 0;
      m_en = 1'b0;
      m_consec = 0;
      m_known = 1'b0;
      m_last = '0;
      m_tx = {TXID, 64'h0};
      pend = 0;
    end else begin
      busy = pend;
      if (pend && cyc == due) begin
        pend = 0;
        if (p_good) begin
          m_payload = p_payload;
          m_valid = 1'b1;
          m_fc = m_fc + 16'd1;
          m_tx = p_tx;
          m_consec = 0;
          m_en = 1'b1;
          if (m_known && p_seq != m_last + 8'd1) m_gap = 1'b1;
          m_last = p_seq;
          m_known = 1'b1;
        end else begin
          if (m_ec < 255) m_ec++;
          if (m_consec < MAXE) m_consec++;
          if (m_consec >= MAXE) m_en = 1'b0;
        end
      end
      if (rx_sync) begin
        if (busy) begin
          if (m_ec < 255) m_ec++;
        end else begin
          pend = 1;
          due = cyc + LAT - 1;
          p_seq = rx_data[8+PW +: 8];
          p_payload = rx_data[8 +: PW];
          p_good = !CRC_ON ||
                   crc_bytes(rx_data, NB - 1) == rx_data[7:0];
          p_tx = {TXID, p_seq, in_payload, 8'h00};
          if (CRC_ON) p_tx[7:0] = crc_bytes(p_tx, NB - 1);
        end
      end
      if (pkg_timeout) begin
        m_en = 1'b0;
        m_known = 1'b0;
      end
    end
    cyc++;
  end

  always @(negedge clk) begin
    if (cyc > 0) begin
      chk("out_payload", out_payload, m_payload);
      chk("out_valid", out_valid, m_valid);
      chk("out_enable", out_enable, m_en && !pkg_timeout);
      chk("tx_data", tx_data, m_tx);
      chk("seq_gap", seq_gap, m_gap);
      chk("frame_count", frame_count, m_fc);
      chk("err_count", err_count, m_ec[7:0]);
      if (out_valid === 1'b1) valid_cnt++;
      if (seq_gap === 1'b1) gap_cnt++;
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] seq,
                      input logic [PW-1:0] pl,
                      input bit bad);
    logic [BS-1:0] f;
    f = {RXID, seq, pl, 8'h00};
    f[7:0] = crc_bytes(f, NB - 1) ^ (bad ? 8'h01 : 8'h00);
    rx_data = f;
    in_payload = ~pl;
    rx_sync = 1'b1;
    @(posedge clk);
    #1;
    rx_sync = 1'b0;
  endtask

  localparam logic [PW-1:0] P5  = 48'h313233343536;
  localparam logic [PW-1:0] P6  = 48'h0A0B0C0D0E0F;
  localparam logic [PW-1:0] P8  = 48'hCAFEF00D1234;
  localparam logic [PW-1:0] P13 = 48'h5A5A5A5A5A5A;
  localparam logic [PW-1:0] P77 = 48'h777777777777;
  localparam logic [PW-1:0] P78 = 48'h787878787878;

  initial begin
    logic [71:0] ascii;
    logic [BS-1:0] v;
    int n, g, vc;
    int ebase, fcb;

    rst = 1'b1;
    rx_sync = 1'b0;
    pkg_timeout = 1'b0;
    rx_data = '0;
    in_payload = '0;
    c_in = 8'h00;
    c_byte = 8'h00;
    tick(3);

    chk("rst_enable", out_enable, 1'b0);
    chk("rst_tx", tx_data, {TXID, 64'h0});
    chk("rst_fc", frame_count, 16'd0);
    chk("rst_ec", err_count, 8'd0);
    chk("rst_valid", out_valid, 1'b0);

    ascii = 72'h313233343536373839;
    for (int i = 0; i < 9; i++) begin
      c_byte = ascii[71-8*i -: 8];
      #1;
      c_in = c_out;
    end
    chk("crc_unit", c_in, 8'hF4);
    v = {ascii, 24'h0};
    chk("crc_model", crc_bytes(v, 9), 8'hF4);

    rst = 1'b0;
    tick(2);

    // good frame: latency and payload
    send(8'd5, P5, 1'b0);
    n = 1;
    while (out_valid !== 1'b1 && n < 40) begin
      tick(1);
      n++;
    end
    chk("latency", n, LAT);
    chk("t1_payload", out_payload, P5);
    chk("t1_tx_hdr", tx_data[BS-1:8], {TXID, 8'h05, ~P5});
`ifndef FRAME_CRC_EN
    chk("t1_tx_crc", tx_data[7:0], 8'h00);
`endif
    chk("t1_enable", out_enable, 1'b1);
    tick(3);

    // sequence gap only on 8
    g = gap_cnt;
    send(8'd6, P6, 1'b0);
    tick(LAT + 1);
    chk("gap_6", gap_cnt, g);
    send(8'd8, P8, 1'b0);
    tick(LAT + 1);
    chk("gap_8", gap_cnt, g + 1);
    chk("t3_fc", frame_count, 16'd3);

    // four bad CRC frames
    for (int i = 0; i < 4; i++) begin
      send(8'(9 + i), P13 ^ PW'(i), 1'b1);
      tick(LAT + 1);
      if (i == 2) chk("bad3_enable", out_enable, 1'b1);
    end
    chk("bad4_err", err_count, CRC_ON ? 8'd4 : 8'd0);
    chk("bad4_enable", out_enable, CRC_ON ? 1'b0 : 1'b1);
    chk("bad4_payload", out_payload,
        CRC_ON ? P8 : (P13 ^ PW'(3)));
    chk("bad4_fc", frame_count, CRC_ON ? 16'd3 : 16'd7);
    send(8'd13, P13, 1'b0);
    tick(LAT + 1);
    chk("recover_enable", out_enable, 1'b1);

    // link timeout
    pkg_timeout = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick(1);
      chk("to_enable", out_enable, 1'b0);
    end
    chk("to_hold", out_payload, P13);
    pkg_timeout = 1'b0;
    tick(1);
    chk("to_after", out_enable, 1'b0);
    g = gap_cnt;
    send(8'd77, P77, 1'b0);
    tick(LAT + 1);
    chk("to_nogap", gap_cnt, g);
    chk("to_reenable", out_enable, 1'b1);

    // overrun: second sync while busy
    ebase = CRC_ON ? 4 : 0;
    fcb = CRC_ON ? 5 : 9;
    send(8'd78, P78, 1'b0);
    if (CRC_ON) tick(2);
    send(8'd200, P5, 1'b0);
    tick(LAT + 3);
    chk("ovr_err", err_count, 8'(ebase + 1));
    chk("ovr_fc", frame_count, 16'(fcb + 1));
    chk("ovr_payload", out_payload, P78);

    // reset in flight
    vc = valid_cnt;
    send(8'd79, P6, 1'b0);
    if (CRC_ON) tick(3);
    rst = 1'b1;
    tick(2);
    rst = 1'b0;
    chk("mid_payload", out_payload, '0);
    chk("mid_enable", out_enable, 1'b0);
    chk("mid_tx", tx_data, {TXID, 64'h0});
    chk("mid_ec", err_count, 8'd0);
    tick(LAT + 5);
    chk("mid_novalid", valid_cnt, vc);
    chk("mid_fc", frame_count, 16'd0);

    g = gap_cnt;
    send(8'd42, P8, 1'b0);
    tick(LAT + 1);
    chk("post_fc", frame_count, 16'd1);
    chk("post_nogap", gap_cnt, g);
    chk("post_payload", out_payload, P8);
    tick(2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
